// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with valid/ready handshake, status flags and iterative shifter
// Optional feature macro: ALU_BARREL_SHIFT_EN (single-cycle barrel shifter, no SHIFT state/counter)
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               op,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic [$clog2(WIDTH)-1:0] shamt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         result,
   output logic                     zero,
   output logic                     carry,
   output logic                     ovf
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [2:0] OP_SRA = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_ADD = 3'd3;
   localparam logic [2:0] OP_SLL = 3'd4;
   localparam logic [2:0] OP_AND = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_XOR = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_ovf;
   logic             accept;

`ifndef ALU_BARREL_SHIFT_EN
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic [2:0]       op_r;
   logic             is_shift;
   logic [WIDTH-1:0] a_step;
   logic [WIDTH-1:0] acc_step;

   // One-bit shift step: SRA keeps the sign bit, SRL/SLL fill with zero
   function automatic logic [WIDTH-1:0] shift1(input logic [2:0] o, input logic [WIDTH-1:0] v);
      case (o)
         OP_SRA:  shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
         OP_SRL:  shift1 = {1'b0, v[WIDTH-1:1]};
         default: shift1 = {v[WIDTH-2:0], 1'b0};
      endcase
   endfunction

   assign is_shift = (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
   // The accept edge already performs the first bit step, so a shift by N is visible after N edges
   assign a_step   = shift1(op, a);
   assign acc_step = shift1(op_r, acc);
`endif

   assign accept = in_valid && in_ready;

   // Single-edge result and flags for every op that does not need the iterative shifter
   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      diff      = {1'b0, a} - {1'b0, b};
      alu_res   = a;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (op)
`ifdef ALU_BARREL_SHIFT_EN
         OP_SRA: alu_res = WIDTH'($signed(a) >>> shamt);
         OP_SRL: alu_res = a >> shamt;
         OP_SLL: alu_res = a << shamt;
`endif
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         default: ;
      endcase
   end

   // Control FSM with registered handshake outputs, result and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
         acc       <= '0;
         cnt       <= '0;
         op_r      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               if (accept) begin
                  in_ready <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
                  if (is_shift && (shamt != '0)) begin
                     op_r <= op;
                     if (shamt == SHW'(1)) begin
                        result    <= a_step;
                        zero      <= (a_step == '0);
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                     end else begin
                        acc   <= a_step;
                        cnt   <= shamt - SHW'(1);
                        state <= SHIFT;
                     end
                  end else
`endif
                  begin
                     result    <= alu_res;
                     zero      <= (alu_res == '0);
                     carry     <= alu_carry;
                     ovf       <= alu_ovf;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
`ifndef ALU_BARREL_SHIFT_EN
            SHIFT: begin
               acc <= acc_step;
               cnt <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  result    <= acc_step;
                  zero      <= (acc_step == '0);
                  carry     <= 1'b0;
                  ovf       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
`endif
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;

   localparam int W = 8;
`ifdef ALU_BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   shamt = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         zero;
   logic         carry;
   logic         ovf;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .carry(carry), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
      int           lat;
   } exp_t;

   exp_t q[$];
   int   acc_cyc = 0;
   bit   seen = 1'b0;
   int   rdy_mode = 0;
   bit   mon_en = 1'b0;
   int   checks = 0;
   int   passed = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic [2:0] s);
      exp_t e;
      logic signed [W-1:0] xs;
      int sx, sy, t;
      xs = x;
      sx = $signed(x);
      sy = $signed(y);
      e.c = 1'b0;
      e.v = 1'b0;
      e.lat = 1;
      case (o)
         3'd0: e.res = xs >>> s;
         3'd1: e.res = x >> s;
         3'd4: e.res = x << s;
         3'd2: begin
            e.res = x - y;
            e.c = (x < y);
            t = sx - sy;
            e.v = (t > 127) || (t < -128);
         end
         3'd3: begin
            e.res = x + y;
            e.c = (int'(x) + int'(y)) > 255;
            t = sx + sy;
            e.v = (t > 127) || (t < -128);
         end
         3'd5: e.res = x & y;
         3'd6: e.res = x | y;
         default: e.res = x ^ y;
      endcase
      if ((o == 3'd0 || o == 3'd1 || o == 3'd4) && s != 0 && !BARREL) e.lat = s;
      e.z = (e.res == 0);
      return e;
   endfunction

   // Compare process: every cycle with a pending op, check handshake, latency and held result
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         case (rdy_mode)
            0: out_ready = ($urandom_range(0, 2) != 0);
            1: out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", out_valid, 0);
            end else begin
               if (!seen) begin
                  chk("latency", cyc - acc_cyc, q[0].lat);
                  seen = 1'b1;
               end
               chk("result", result, q[0].res);
               chk("zero", zero, q[0].z);
               chk("carry", carry, q[0].c);
               chk("ovf", ovf, q[0].v);
               chk("in_ready_while_done", in_ready, 0);
               if (out_ready) begin
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end else if (q.size() != 0) begin
            chk("in_ready_while_busy", in_ready, 0);
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2:0] s, input exp_t e);
      int n;
      n = 0;
      @(negedge clk); #1;
      op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         checks++;
         $display("FAIL accept_timeout: in_ready stayed %0b for %0d cycles", in_ready, n);
      end
      acc_cyc = cyc;
      q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 3'($urandom); a = W'($urandom); b = W'($urandom); shamt = 3'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 300) begin
         checks++;
         $display("FAIL drain_timeout: %0d ops still pending", q.size());
         q.delete();
      end
   endtask

   // Directed vectors with hand-computed expectations
   typedef struct {
      logic [2:0]   o;
      logic [W-1:0] x, y;
      logic [2:0]   s;
      logic [W-1:0] res;
      logic         z, c, v;
      int           lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      exp_t e;
      vecs.push_back('{3'd3, 8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1});
      vecs.push_back('{3'd2, 8'h05, 8'h05, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{3'd2, 8'h03, 8'h05, 3'd0, 8'hFE, 1'b0, 1'b1, 1'b0, 1});
      vecs.push_back('{3'd0, 8'h90, 8'h00, 3'd3, 8'hF2, 1'b0, 1'b0, 1'b0, BARREL ? 1 : 3});
      vecs.push_back('{3'd1, 8'h90, 8'h00, 3'd3, 8'h12, 1'b0, 1'b0, 1'b0, BARREL ? 1 : 3});
      vecs.push_back('{3'd4, 8'h81, 8'h00, 3'd1, 8'h02, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{3'd0, 8'hA5, 8'h00, 3'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{3'd5, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{3'd6, 8'hF0, 8'h3C, 3'd0, 8'hFC, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{3'd7, 8'hF0, 8'h3C, 3'd0, 8'hCC, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{3'd3, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1});
      vecs.push_back('{3'd4, 8'h01, 8'h00, 3'd7, 8'h80, 1'b0, 1'b0, 1'b0, BARREL ? 1 : 7});
      vecs.push_back('{3'd0, 8'h80, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b0, BARREL ? 1 : 7});

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_result", result, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_flags", {zero, carry, ovf}, 0);
      chk("reset_in_ready", in_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_reset", in_ready, 1);
      mon_en = 1'b1;
      rdy_mode = 2;

      // Directed vectors: model pinned against literals, DUT checked against literals
      foreach (vecs[i]) begin
         e = model(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].s);
         chk("model_pin", {e.res, e.z, e.c, e.v, e.lat[7:0]},
             {vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].lat[7:0]});
         e.res = vecs[i].res; e.z = vecs[i].z; e.c = vecs[i].c; e.v = vecs[i].v;
         e.lat = vecs[i].lat;
         issue(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].s, e);
         wait_idle();
      end

      // Backpressure: result held for several cycles, then released
      rdy_mode = 1;
      issue(3'd3, 8'h7F, 8'h01, 3'd0, model(3'd3, 8'h7F, 8'h01, 3'd0));
      repeat (6) @(negedge clk);
      chk("bp_out_valid_held", out_valid, 1);
      rdy_mode = 2;
      wait_idle();
      @(negedge clk); #1;
      chk("bp_in_ready_after", in_ready, 1);
      chk("bp_out_valid_after", out_valid, 0);

      // Randomized ops with random consumer backpressure
      rdy_mode = 0;
      for (int i = 0; i < 200; i++) begin
         logic [2:0] ro, rs;
         logic [W-1:0] ra, rb;
         ro = 3'($urandom);
         rs = 3'($urandom);
         ra = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
         issue(ro, ra, rb, rs, model(ro, ra, rb, rs));
      end
      wait_idle();

      // Reset in the middle of a long shift
      rdy_mode = 1;
      issue(3'd1, 8'hFF, 8'h00, 3'd7, model(3'd1, 8'hFF, 8'h00, 3'd7));
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_result", result, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_flags", {zero, carry, ovf}, 0);
      chk("midrst_in_ready", in_ready, 0);
      q.delete();
      seen = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("postrst_in_ready", in_ready, 1);
      chk("postrst_out_valid", out_valid, 0);
      rdy_mode = 2;
      e.res = 8'h02; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.lat = 1;
      issue(3'd3, 8'h01, 8'h01, 3'd0, e);
      wait_idle();

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
